r2r_dac_player: RTL

Playback engine that drives the external R-2R ladder as a DAC from a stream of digital samples. This is the write side of the ladder interface, where the ADC path is the read side.
- Upstream logic pushes samples through a valid/ready handshake into an internal FIFO.
- The block pops one sample per programmable sample period and holds it on R2R_out.
- Prime/run sequencing and underrun detection keep the analog output glitch-free.

---
 rtl/r2r_dac_player.sv | 135 +++++++++++++
 1 files changed

// File: rtl/r2r_dac_player.sv
// R-2R ladder playback engine: sample FIFO, rate divider and prime/run sequencing.
// Optional saturating underrun counter built when R2R_UNDERRUN_CNT_EN is defined.
module r2r_dac_player #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter int DIV_W       = 20,
  parameter int PRIME_LEVEL = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [DIV_W-1:0]         rate_div,
  input  logic [WIDTH-1:0]         s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [WIDTH-1:0]         R2R_out,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     sample_pulse,
  output logic                     underrun_pulse,
  output logic [15:0]              underrun_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LV  = (AW+1)'(DEPTH);
  localparam logic [AW:0] PRIME_LV = (AW+1)'(PRIME_LEVEL);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [1:0]       state;
  logic [DIV_W-1:0] div_cnt, div_last;
  logic             push, pop, tick, underrun;

  // Terminal count for a period; a divide of 0 behaves like 1.
  function automatic logic [DIV_W-1:0] period_last(input logic [DIV_W-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  assign s_ready  = (count != FULL_LV);
  assign level    = count;
  assign push     = s_valid && s_ready;
  assign tick     = (state == S_RUN) && enable && (div_cnt == div_last);
  assign pop      = tick && (count != '0);
  assign underrun = tick && (count == '0);

  // FIFO storage holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      div_last <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) state <= S_PRIME;
        end
        S_PRIME: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (count >= PRIME_LV) begin
            state    <= S_RUN;
            div_cnt  <= '0;
            div_last <= period_last(rate_div);
          end
        end
        S_RUN: begin
          if (!enable) begin
            state   <= S_IDLE;
            div_cnt <= '0;
          end else if (tick) begin
            div_cnt  <= '0;
            div_last <= period_last(rate_div);
            if (underrun) state <= S_PRIME;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          div_cnt <= '0;
        end
      endcase
    end
  end

  // Ladder code and strobes change on the same edge as the pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      R2R_out        <= '0;
      sample_pulse   <= 1'b0;
      underrun_pulse <= 1'b0;
    end else begin
      if (pop) R2R_out <= mem[rd_ptr];
      sample_pulse   <= pop;
      underrun_pulse <= underrun;
    end
  end

`ifdef R2R_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_count <= '0;
    end else if (underrun && (underrun_count != 16'hFFFF)) begin
      underrun_count <= underrun_count + 1'b1;
    end
  end
`else
  assign underrun_count = '0;
`endif

endmodule
